// File: rtl/block_align_unit_pkg.sv
// sd4_align_pkg: shared widths, guard derivation, FSM states and term record for block alignment.
package sd4_align_pkg;
  localparam int N_TERMS_DEF = 4;
  localparam int MANT_W = 11;
  localparam int EXP_W = 6;
  localparam int SUM_W = 20;
  function automatic int guard_bits(int n_terms);
    return SUM_W - 1 - $clog2(n_terms) - MANT_W;
  endfunction
  typedef enum logic {LOAD, EMIT} state_e;
  typedef struct packed {
    logic sign;
    logic [MANT_W-1:0] mant;
    logic signed [EXP_W-1:0] exp;
  } term_t;
endpackage

// File: rtl/block_align_unit_if.sv
// block_align_unit_if: term input and aligned output handshake bundle.
import sd4_align_pkg::*;
interface block_align_unit_if;
  logic in_valid;
  logic in_ready;
  logic in_sign;
  logic [MANT_W-1:0] in_mant;
  logic signed [EXP_W-1:0] in_exp;
  logic out_valid;
  logic out_ready;
  logic [SUM_W-1:0] out_value;
  logic signed [EXP_W-1:0] out_exp_max;
  logic out_last;
  modport slave(input in_valid, in_sign, in_mant, in_exp, out_ready,
                output in_ready, out_valid, out_value, out_exp_max, out_last);
  modport master(output in_valid, in_sign, in_mant, in_exp, out_ready,
                 input in_ready, out_valid, out_value, out_exp_max, out_last);
endinterface

// File: rtl/block_align_unit_align_shift.sv
// align_shift: aligns one term to the block max exponent and applies its sign.
// Build with ALIGN_STICKY_EN to OR shifted-out bits into the LSB.
module align_shift
  import sd4_align_pkg::*;
#(
  parameter int GUARD = guard_bits(N_TERMS_DEF)
) (
  input  term_t term_i,
  input  logic signed [EXP_W-1:0] exp_max_i,
  output logic [SUM_W-1:0] value_o
);
  localparam int MG = MANT_W + GUARD;
  logic [MG-1:0] mag, aligned;
  logic [EXP_W:0] shift;
  logic [SUM_W-1:0] ext;
  logic sticky;
  // Shifts of MG or more flush to zero by shift semantics; zero terms stay zero for any shift.
  always_comb begin
    mag = {term_i.mant, {GUARD{1'b0}}};
    shift = {exp_max_i[EXP_W-1], exp_max_i} - {term_i.exp[EXP_W-1], term_i.exp};
    aligned = mag >> shift;
`ifdef ALIGN_STICKY_EN
    sticky = |(mag & ~({MG{1'b1}} << shift));
`else
    sticky = 1'b0;
`endif
    ext = SUM_W'(aligned) | SUM_W'(sticky);
    value_o = term_i.sign ? -ext : ext;
  end
endmodule

// File: rtl/block_align_unit.sv
// block_align_unit: collects a block of terms, tracks max exponent, streams aligned fixed-point terms.
// Optional ALIGN_STICKY_EN enables sticky rounding in align_shift.
module block_align_unit
  import sd4_align_pkg::*;
#(
  parameter int N_TERMS = N_TERMS_DEF
) (
  input logic clk,
  input logic rst,
  block_align_unit_if.slave bus
);
  localparam int CW = $clog2(N_TERMS);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, idx_q;
  term_t buf_q [N_TERMS];
  logic signed [EXP_W-1:0] exp_max_q;
  logic found_nz_q;
  logic in_hs, out_hs, last, nz;
  logic [SUM_W-1:0] value;
  align_shift #(.GUARD(guard_bits(N_TERMS))) u_shift (
    .term_i(buf_q[idx_q]),
    .exp_max_i(exp_max_q),
    .value_o(value)
  );
  always_comb begin
    bus.in_ready = state_q == LOAD;
    bus.out_valid = state_q == EMIT;
    in_hs = bus.in_valid && bus.in_ready;
    out_hs = bus.out_valid && bus.out_ready;
    last = idx_q == CW'(N_TERMS - 1);
    nz = bus.in_mant != '0;
    bus.out_value = bus.out_valid ? value : '0;
    bus.out_exp_max = bus.out_valid ? exp_max_q : '0;
    bus.out_last = bus.out_valid && last;
    state_d = (in_hs && cnt_q == CW'(N_TERMS - 1)) ? EMIT : (out_hs && last) ? LOAD : state_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= LOAD;
    else state_q <= state_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      buf_q <= '{default: '0};
      exp_max_q <= '0;
      found_nz_q <= 1'b0;
    end else begin
      if (in_hs) begin
        buf_q[cnt_q] <= '{bus.in_sign, bus.in_mant, bus.in_exp};
        cnt_q <= cnt_q + CW'(1);
        if (nz && (!found_nz_q || bus.in_exp > exp_max_q)) exp_max_q <= bus.in_exp;
        if (nz) found_nz_q <= 1'b1;
      end
      // Closing handshake rearms the next block with a clean max tracker.
      if (out_hs) begin
        idx_q <= last ? '0 : idx_q + CW'(1);
        if (last) begin
          cnt_q <= '0;
          exp_max_q <= '0;
          found_nz_q <= 1'b0;
        end
      end
    end
  end
endmodule
